jpd_pad_reader: RTL

//  Pad-side counterpart of the console joypad register block.

---
 rtl/jpd_pkg.sv | 73 +++++++
 rtl/jpd_sync2.sv | 25 ++
 rtl/jpd_pad_reader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/jpd_pkg.sv
// Shared definitions for the joypad pad reader: vector layout, pad serial bit
// positions, FSM state encoding and the serial-to-vector mapping.
package jpd_pkg;

    localparam int JPD_UP     = 9;
    localparam int JPD_DOWN   = 8;
    localparam int JPD_LEFT   = 7;
    localparam int JPD_RIGHT  = 6;
    localparam int JPD_B      = 5;
    localparam int JPD_A      = 4;
    localparam int JPD_TB     = 3;
    localparam int JPD_TA     = 2;
    localparam int JPD_SELECT = 1;
    localparam int JPD_START  = 0;

    localparam int NES_A      = 0;
    localparam int NES_B      = 1;
    localparam int NES_SELECT = 2;
    localparam int NES_START  = 3;
    localparam int NES_UP     = 4;
    localparam int NES_DOWN   = 5;
    localparam int NES_LEFT   = 6;
    localparam int NES_RIGHT  = 7;

    localparam int SNES_B      = 0;
    localparam int SNES_Y      = 1;
    localparam int SNES_SELECT = 2;
    localparam int SNES_START  = 3;
    localparam int SNES_UP     = 4;
    localparam int SNES_DOWN   = 5;
    localparam int SNES_LEFT   = 6;
    localparam int SNES_RIGHT  = 7;
    localparam int SNES_A      = 8;
    localparam int SNES_X      = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_GAP    = 3'd2,
        ST_CLK_LO = 3'd3,
        ST_CLK_HI = 3'd4,
        ST_DONE   = 3'd5
    } jpd_state_e;

    // Only serial bits 0..9 carry buttons that reach the vector.
    function automatic logic [9:0] jpd_map(input logic snes, input logic [9:0] sr);
        logic [9:0] v;
        v = '0;
        if (snes) begin
            v[JPD_UP]     = sr[SNES_UP];
            v[JPD_DOWN]   = sr[SNES_DOWN];
            v[JPD_LEFT]   = sr[SNES_LEFT];
            v[JPD_RIGHT]  = sr[SNES_RIGHT];
            v[JPD_B]      = sr[SNES_B];
            v[JPD_A]      = sr[SNES_A];
            v[JPD_TB]     = sr[SNES_Y];
            v[JPD_TA]     = sr[SNES_X];
            v[JPD_SELECT] = sr[SNES_SELECT];
            v[JPD_START]  = sr[SNES_START];
        end else begin
            v[JPD_UP]     = sr[NES_UP];
            v[JPD_DOWN]   = sr[NES_DOWN];
            v[JPD_LEFT]   = sr[NES_LEFT];
            v[JPD_RIGHT]  = sr[NES_RIGHT];
            v[JPD_B]      = sr[NES_B];
            v[JPD_A]      = sr[NES_A];
            v[JPD_SELECT] = sr[NES_SELECT];
            v[JPD_START]  = sr[NES_START];
        end
        return v;
    endfunction

endpackage

// File: rtl/jpd_sync2.sv
// Two-flop synchroniser for an asynchronous pad data line; resets to the
// idle (released) level of 1.
module jpd_sync2 (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_meta <= 1'b1;
            r_q    <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/jpd_pad_reader.sv
// Polls two NES/SNES pads over a shared latch/clock link and presents their
// buttons as active-high 10-bit vectors, updated once per complete frame.
//
// state  | meaning
// IDLE   | lines idle, waiting for a poll tick
// LATCH  | latch high for two half periods, pads capture buttons
// GAP    | latch low one half period, bit 0 sampled at the end
// CLK_LO | pad clock low one half period
// CLK_HI | pad clock high one half period, next bit sampled at the end
// DONE   | load output vectors and pulse o_jpd_val
module jpd_pad_reader
    import jpd_pkg::*;
#(
    parameter int PAD_MODE = 0,
    parameter int HALF_DIV = 300,
    parameter int POLL_DIV = 833333
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_en,
    output logic       o_pad_latch,
    output logic       o_pad_clk,
    input  logic       i_pad1_data,
    input  logic       i_pad2_data,
    output logic [9:0] o_jpd_1p,
    output logic [9:0] o_jpd_2p,
    output logic       o_jpd_val
);

    localparam int NBITS = (PAD_MODE == 0) ? 8 : 16;
    localparam int PHW   = $clog2(2 * HALF_DIV);
    localparam int PLW   = $clog2(POLL_DIV);
    localparam int BCW   = $clog2(NBITS);

    localparam logic [PHW-1:0] PH_LATCH  = PHW'(2 * HALF_DIV - 1);
    localparam logic [PHW-1:0] PH_HALF   = PHW'(HALF_DIV - 1);
    localparam logic [PLW-1:0] POLL_LAST = PLW'(POLL_DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(NBITS - 1);
    localparam logic           IS_SNES   = (PAD_MODE != 0);

    logic             w_pad1;
    logic             w_pad2;
    logic             w_tick;
    logic [15:0]      w_sr1_ext;
    logic [15:0]      w_sr2_ext;
    logic             w_unused_hi;

    logic [PLW-1:0]   r_poll;
    jpd_state_e       r_state;
    logic [PHW-1:0]   r_phase;
    logic [BCW-1:0]   r_bit;
    logic [NBITS-1:0] r_sr1;
    logic [NBITS-1:0] r_sr2;
    logic             r_latch;
    logic             r_pclk;
    logic             r_val;
    logic [9:0]       r_jpd1;
    logic [9:0]       r_jpd2;

    jpd_sync2 u_sync_pad1 (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_d    (i_pad1_data),
        .o_q    (w_pad1)
    );

    jpd_sync2 u_sync_pad2 (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_d    (i_pad2_data),
        .o_q    (w_pad2)
    );

    // Poll counter freezes (rather than clears) while disabled.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_poll <= '0;
        end else if (i_en) begin
            r_poll <= (r_poll == POLL_LAST) ? '0 : r_poll + PLW'(1);
        end
    end

    assign w_tick = i_en && (r_poll == POLL_LAST);

    // Zero-extend so both pad modes feed the same mapping; L/R/ID bits are dropped.
    assign w_sr1_ext   = 16'(r_sr1);
    assign w_sr2_ext   = 16'(r_sr2);
    assign w_unused_hi = ^{w_sr1_ext[15:10], w_sr2_ext[15:10]};

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
            r_bit   <= '0;
            r_sr1   <= '0;
            r_sr2   <= '0;
            r_latch <= 1'b0;
            r_pclk  <= 1'b1;
            r_val   <= 1'b0;
            r_jpd1  <= '0;
            r_jpd2  <= '0;
        end else begin
            r_val <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state <= ST_LATCH;
                        r_latch <= 1'b1;
                        r_phase <= PH_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (r_phase == '0) begin
                        r_state <= ST_GAP;
                        r_latch <= 1'b0;
                        r_phase <= PH_HALF;
                    end else begin
                        r_phase <= r_phase - PHW'(1);
                    end
                end
                ST_GAP: begin
                    if (r_phase == '0) begin
                        r_sr1   <= {~w_pad1, r_sr1[NBITS-1:1]};
                        r_sr2   <= {~w_pad2, r_sr2[NBITS-1:1]};
                        r_bit   <= '0;
                        r_state <= ST_CLK_LO;
                        r_pclk  <= 1'b0;
                        r_phase <= PH_HALF;
                    end else begin
                        r_phase <= r_phase - PHW'(1);
                    end
                end
                ST_CLK_LO: begin
                    if (r_phase == '0) begin
                        r_state <= ST_CLK_HI;
                        r_pclk  <= 1'b1;
                        r_phase <= PH_HALF;
                    end else begin
                        r_phase <= r_phase - PHW'(1);
                    end
                end
                ST_CLK_HI: begin
                    if (r_phase == '0) begin
                        if (r_bit == BIT_LAST) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_sr1   <= {~w_pad1, r_sr1[NBITS-1:1]};
                            r_sr2   <= {~w_pad2, r_sr2[NBITS-1:1]};
                            r_bit   <= r_bit + BCW'(1);
                            r_state <= ST_CLK_LO;
                            r_pclk  <= 1'b0;
                            r_phase <= PH_HALF;
                        end
                    end else begin
                        r_phase <= r_phase - PHW'(1);
                    end
                end
                ST_DONE: begin
                    r_jpd1  <= jpd_map(IS_SNES, w_sr1_ext[9:0]);
                    r_jpd2  <= jpd_map(IS_SNES, w_sr2_ext[9:0]);
                    r_val   <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_latch <= 1'b0;
                    r_pclk  <= 1'b1;
                end
            endcase
        end
    end

    assign o_pad_latch = r_latch;
    assign o_pad_clk   = r_pclk;
    assign o_jpd_1p    = r_jpd1;
    assign o_jpd_2p    = r_jpd2;
    assign o_jpd_val   = r_val;

endmodule
